layer_sched: RTL

Sequencer for one fully connected layer. It walks every output neuron, streams that neuron's inputs and weights from synchronous-read memories through one serial multiply-accumulate, adds that neuron's bias once, and saturates the result to DW bits. Each result is presented on a valid/ready output port. The block sits between the activation/weight/bias buffers and the next layer's input buffer, and replaces the fully parallel single-node datapath wherever area matters more than latency.

---
 rtl/layer_sched_if.sv | 35 +++
 rtl/layer_sched.sv | 136 +++++++++++++
 2 files changed

// File: rtl/layer_sched_if.sv
// Port bundle for layer_sched: control, activation/weight/bias read ports and
// the valid/ready result stream. master = sequencer side, slave = environment side.
interface layer_sched_if #(
   parameter int IN_NODES  = 200,
   parameter int OUT_NODES = 10,
   parameter int DW        = 16
);
   localparam int IW  = $clog2(IN_NODES);
   localparam int OW  = (OUT_NODES > 1) ? $clog2(OUT_NODES) : 1;
   localparam int WAW = $clog2(IN_NODES * OUT_NODES);

   logic           start;
   logic           busy;
   logic           done;
   logic [IW-1:0]  in_addr;
   logic [DW-1:0]  in_data;
   logic [WAW-1:0] w_addr;
   logic [DW-1:0]  w_data;
   logic [OW-1:0]  b_addr;
   logic [DW-1:0]  b_data;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_data;
   logic [OW-1:0]  out_idx;

   modport master (
      input  start, in_data, w_data, b_data, out_ready,
      output busy, done, in_addr, w_addr, b_addr, out_valid, out_data, out_idx
   );

   modport slave (
      output start, in_data, w_data, b_data, out_ready,
      input  busy, done, in_addr, w_addr, b_addr, out_valid, out_data, out_idx
   );
endinterface

// File: rtl/layer_sched.sv
// Serial fully-connected layer: one MAC per cycle per neuron, bias added once,
// result saturated to DW bits and handed out over a valid/ready port.
module layer_sched #(
   parameter int IN_NODES  = 200,
   parameter int OUT_NODES = 10,
   parameter int DW        = 16
) (
   input  logic          clk,
   input  logic          rst,
   layer_sched_if.master bus
);
   localparam int IW   = $clog2(IN_NODES);
   localparam int OW   = (OUT_NODES > 1) ? $clog2(OUT_NODES) : 1;
   localparam int WAW  = $clog2(IN_NODES * OUT_NODES);
   localparam int ACCW = 2 * DW + IW + 1;

   localparam logic [IW-1:0]   LAST_I  = IW'(IN_NODES - 1);
   localparam logic [OW-1:0]   LAST_N  = OW'(OUT_NODES - 1);
   localparam logic [WAW-1:0]  W_STEP  = WAW'(IN_NODES);
   localparam logic [ACCW-1:0] SAT_MAX = {{(ACCW - DW){1'b0}}, {DW{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE, S_MAC, S_DRAIN, S_BIAS, S_OUT, S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   i_q;
   logic [OW-1:0]   n_q;
   logic [WAW-1:0]  wbase_q;
   logic [WAW-1:0]  w_addr_q;
   logic [ACCW-1:0] acc_q;
   logic            acc_en_q;
   logic [DW-1:0]   out_data_q;
   logic [OW-1:0]   out_idx_q;
   logic [2*DW-1:0] prod;
   logic [ACCW-1:0] sum;
   logic            busy_c, done_c, valid_c;
   logic            last_n;

   assign prod   = {{DW{1'b0}}, bus.in_data} * {{DW{1'b0}}, bus.w_data};
   assign sum    = acc_q + ACCW'(bus.b_data);
   assign last_n = (n_q == LAST_N);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can
      // leave one unassigned and infer a latch.
      state_nxt = state;
      busy_c    = 1'b1;
      done_c    = 1'b0;
      valid_c   = 1'b0;
      case (state)
         S_IDLE: begin
            busy_c = 1'b0;
            if (bus.start) state_nxt = S_MAC;
         end
         S_MAC:   if (i_q == LAST_I) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_BIAS;
         S_BIAS:  state_nxt = S_OUT;
         S_OUT: begin
            valid_c = 1'b1;
            if (bus.out_ready) state_nxt = last_n ? S_DONE : S_MAC;
         end
         S_DONE: begin
            done_c    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Memory data lags the address by one cycle, so the first MAC cycle of a
   // neuron has no product yet and the last product lands in DRAIN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_q        <= '0;
         n_q        <= '0;
         wbase_q    <= '0;
         w_addr_q   <= '0;
         acc_q      <= '0;
         acc_en_q   <= 1'b0;
         out_data_q <= '0;
         out_idx_q  <= '0;
      end else begin
         acc_en_q <= (state == S_MAC);
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  i_q      <= '0;
                  n_q      <= '0;
                  wbase_q  <= '0;
                  w_addr_q <= '0;
                  acc_q    <= '0;
               end
            end
            S_MAC: begin
               if (acc_en_q) acc_q <= acc_q + ACCW'(prod);
               if (i_q != LAST_I) begin
                  i_q      <= i_q + IW'(1);
                  w_addr_q <= w_addr_q + WAW'(1);
               end
            end
            S_DRAIN: acc_q <= acc_q + ACCW'(prod);
            S_BIAS: begin
               out_data_q <= (sum > SAT_MAX) ? '1 : sum[DW-1:0];
               out_idx_q  <= n_q;
            end
            S_OUT: begin
               if (bus.out_ready && !last_n) begin
                  n_q      <= n_q + OW'(1);
                  wbase_q  <= wbase_q + W_STEP;
                  w_addr_q <= wbase_q + W_STEP;
                  i_q      <= '0;
                  acc_q    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.out_valid = valid_c;
   assign bus.out_data  = out_data_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.in_addr   = i_q;
   assign bus.w_addr    = w_addr_q;
   assign bus.b_addr    = n_q;
endmodule
